bcd_conv_seq: RTL and testbench
===============================

// Module: bcd_conv_seq
// PURPOSE
//  Sequential, parametrised binary-to-BCD converter using the shift-add-3
//  (double-dabble) algorithm, one input bit per clock. Feeds the seven-seg
//  display path for values wider than 8 bits with a start/done handshake.
//  Also provides a leading-zero blank mask and a digit-overflow flag.
// PARAMETERS
//  WIDTH   8  binary input width in bits (>=2)
//  DIGITS  3  BCD output digits (>=1); sized by user, overflow is flagged
// PORTS
//  clk     in   1          system clock, rising edge
//  rst_n   in   1          reset: synchronous, active-low
//  start   in   1          request conversion; sampled only when ready=1
//  bin     in   WIDTH      binary operand, captured on accepted start
//  ready   out  1          1 = idle, start will be accepted
//  busy    out  1          1 = conversion in progress (SHIFT or DONE)
//  done    out  1          one-cycle pulse: bcd/blank/ovf valid and updated
//  bcd     out  4*DIGITS   result; digit k = bcd[4k+3:4k], k=0 least significant
//  blank   out  DIGITS     1 = digit is a leading zero; bit 0 always 0
//  ovf     out  1          1 = result did not fit in DIGITS digits
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low. On a clk edge with rst_n=0:
//    state=IDLE, ready=1, busy=0, done=0, bcd=0, ovf=0,
//    blank={DIGITS-1{1'b1}},1'b0}. Reset mid-conversion aborts, no done pulse.
//  - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE: ready=1. Edge with start=1: load shift reg <= bin, scratch digits <= 0,
//      bit counter <= WIDTH-1, ovf scratch <= 0; go to SHIFT.
//    SHIFT: each edge performs one iteration: every scratch digit >=5 gets +3
//      (4-bit, no carry), then {digits, shift reg} shifts left by 1. The bit
//      leaving the top digit ORs into ovf scratch. After WIDTH iterations
//      (counter reaches 0), go to DONE and register outputs on that same edge.
//    DONE: done=1 for exactly one cycle, busy=1, ready=0; next edge -> IDLE.
//  - Latency: start sampled at edge E0; done=1 in the cycle after edge E(WIDTH).
//    Throughput: one conversion per WIDTH+2 cycles (start may be held high).
//  - Output registers change only on the edge entering DONE and hold until the
//    next conversion's DONE or reset.
//  - Overflow: if ovf scratch=1 OR any final digit >9, drive ovf=1 and bcd all
//    4'h9 (saturate). Otherwise ovf=0, bcd = exact decimal value.
//  - blank[k]=1 iff digits k..DIGITS-1 are all zero and k>0; computed from
//    final bcd. When ovf=1, blank = 0.
//  - start while ready=0 is ignored (no queuing); bin changes after capture
//    have no effect.
//  - ready/busy are mutually exclusive in every cycle out of reset.
// TESTING
//  1. W=8,D=3: bin=255, start 1 cycle -> done exactly 8 cycles after
//     sampling edge, bcd=12'h255, blank=3'b000, ovf=0.
//  2. W=8,D=3: bin=0 -> bcd=12'h000, blank=3'b110; bin=7 -> 12'h007,
//     blank=3'b110; bin=40 -> 12'h040, blank=3'b100.
//  3. W=16,D=5: bin=65535 -> bcd=20'h65535, ovf=0; bin=1000 -> 20'h01000,
//     blank=5'b10000.
//  4. W=8,D=2: bin=100 -> ovf=1, bcd=8'h99, blank=2'b00; then bin=99 ->
//     ovf=0, bcd=8'h99.
//  5. Start pulsed on every cycle during SHIFT with changing bin -> no effect,
//     single done; rst_n=0 at iteration 4 -> no done, outputs at reset values,
//     ready=1 next cycle.
//  6. W=8,D=3 sweep bin=0..255 back-to-back with start held high -> every
//     result matches a decimal model, done spacing = 10 cycles.

Source files
------------

// File: rtl/bcd_conv_seq_if.sv
// Start/done handshake and result bundle for the sequential binary-to-BCD converter.
// The master side requests conversions; the slave side is the converter itself.
interface bcd_conv_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  ovf;

    modport master (
        output start, bin,
        input  ready, busy, done, bcd, blank, ovf
    );

    modport slave (
        input  start, bin,
        output ready, busy, done, bcd, blank, ovf
    );
endinterface

// File: rtl/bcd_conv_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Produces a leading-zero blank mask and saturates to all nines on digit overflow.
module bcd_conv_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_conv_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIGITS-1:0]   BLANK_RST = {DIGITS{1'b1}} << 1;
    localparam logic [4*DIGITS-1:0] SAT       = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic [WIDTH-1:0]      shreg;
    logic [WIDTH-1:0]      sh_next;
    logic [4*DIGITS-1:0]   digits;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   dig_next;
    logic [CW-1:0]         cnt;
    logic                  ovf_s;
    logic                  ovf_next;
    logic                  all_zero;
    logic [DIGITS-1:0]     blank_next;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [DIGITS-1:0]     blank_q;
    logic                  ovf_q;
    logic                  ready_c;
    logic                  busy_c;
    logic                  done_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy_c = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step; the bit pushed out of the top digit means the value
    // no longer fits, and the blank mask scans down from the most significant digit.
    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = (digits[4*k +: 4] >= 4'd5) ? digits[4*k +: 4] + 4'd3
                                                        : digits[4*k +: 4];
        end
        dig_next = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
        sh_next  = {shreg[WIDTH-2:0], 1'b0};
        ovf_next = ovf_s | adj[4*DIGITS-1];
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_next[4*k +: 4] > 4'd9) begin
                ovf_next = 1'b1;
            end
        end
        all_zero   = 1'b1;
        blank_next = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero      = all_zero & (dig_next[4*k +: 4] == 4'd0);
            blank_next[k] = all_zero & ~ovf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= '0;
            digits  <= '0;
            cnt     <= '0;
            ovf_s   <= 1'b0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg  <= bus.bin;
                        digits <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        ovf_s  <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg  <= sh_next;
                    digits <= dig_next;
                    cnt    <= cnt - CW'(1);
                    ovf_s  <= ovf_next;
                    if (cnt == '0) begin
                        bcd_q   <= ovf_next ? SAT : dig_next;
                        blank_q <= blank_next;
                        ovf_q   <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = ready_c;
    assign bus.busy  = busy_c;
    assign bus.done  = done_c;
    assign bus.bcd   = bcd_q;
    assign bus.blank = blank_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed bench for bcd_conv_seq in three sizes (8/3, 16/5, 8/2), with an
// exhaustive back-to-back sweep of the 8-bit, 3-digit converter.
module tb_bcd_conv_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    int   lat;
    int   dones;
    int   cyc;
    int   last;
    int   n;
    logic [11:0] e_bcd;
    logic [2:0]  e_blank;

    always #5 clk = ~clk;

    bcd_conv_seq_if #(.WIDTH(8),  .DIGITS(3)) if83 ();
    bcd_conv_seq_if #(.WIDTH(16), .DIGITS(5)) if165 ();
    bcd_conv_seq_if #(.WIDTH(8),  .DIGITS(2)) if82 ();

    bcd_conv_seq #(.WIDTH(8),  .DIGITS(3)) dut83  (.clk(clk), .rst_n(rst_n), .bus(if83.slave));
    bcd_conv_seq #(.WIDTH(16), .DIGITS(5)) dut165 (.clk(clk), .rst_n(rst_n), .bus(if165.slave));
    bcd_conv_seq #(.WIDTH(8),  .DIGITS(2)) dut82  (.clk(clk), .rst_n(rst_n), .bus(if82.slave));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic doneOf(input int sel);
        case (sel)
            0:       return if83.done;
            1:       return if165.done;
            default: return if82.done;
        endcase
    endfunction

    task automatic driveStart(input int sel, input logic [15:0] value, input logic st);
        case (sel)
            0:       begin if83.bin  = value[7:0]; if83.start  = st; end
            1:       begin if165.bin = value;      if165.start = st; end
            default: begin if82.bin  = value[7:0]; if82.start  = st; end
        endcase
    endtask

    // Pulse start for one cycle, then count negedges from the sampling edge to done.
    task automatic applyStimulus(input int sel, input logic [15:0] value, output int latency);
        @(negedge clk);
        driveStart(sel, value, 1'b1);
        @(negedge clk);
        driveStart(sel, value, 1'b0);
        latency = 0;
        while (!doneOf(sel) && latency < 40) begin
            @(negedge clk);
            latency++;
        end
        checkOutput("done_seen", 32'(doneOf(sel)), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        driveStart(0, 16'd0, 1'b0);
        driveStart(1, 16'd0, 1'b0);
        driveStart(2, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(if83.ready), 32'd1);
        checkOutput("rst_busy",  32'(if83.busy),  32'd0);
        checkOutput("rst_done",  32'(if83.done),  32'd0);
        checkOutput("rst_bcd",   32'(if83.bcd),   32'h000);
        checkOutput("rst_blank", 32'(if83.blank), 32'b110);
        checkOutput("rst_ovf",   32'(if83.ovf),   32'd0);
        checkOutput("rst_blank_d5", 32'(if165.blank), 32'b11110);
        rst_n = 1'b1;

        $display("[TB] 8-bit/3-digit directed values");
        applyStimulus(0, 16'd255, lat);
        checkOutput("t1_latency", 32'(lat), 32'd8);
        checkOutput("t1_bcd",   32'(if83.bcd),   32'h255);
        checkOutput("t1_blank", 32'(if83.blank), 32'b000);
        checkOutput("t1_ovf",   32'(if83.ovf),   32'd0);
        applyStimulus(0, 16'd0, lat);
        checkOutput("t2_0_bcd",   32'(if83.bcd),   32'h000);
        checkOutput("t2_0_blank", 32'(if83.blank), 32'b110);
        applyStimulus(0, 16'd7, lat);
        checkOutput("t2_7_bcd",   32'(if83.bcd),   32'h007);
        checkOutput("t2_7_blank", 32'(if83.blank), 32'b110);
        applyStimulus(0, 16'd40, lat);
        checkOutput("t2_40_bcd",   32'(if83.bcd),   32'h040);
        checkOutput("t2_40_blank", 32'(if83.blank), 32'b100);
        repeat (3) @(negedge clk);
        checkOutput("t2_hold_bcd", 32'(if83.bcd), 32'h040);

        $display("[TB] 16-bit/5-digit directed values");
        applyStimulus(1, 16'd65535, lat);
        checkOutput("t3_latency", 32'(lat), 32'd16);
        checkOutput("t3_max_bcd",   32'(if165.bcd),   32'h65535);
        checkOutput("t3_max_ovf",   32'(if165.ovf),   32'd0);
        checkOutput("t3_max_blank", 32'(if165.blank), 32'b00000);
        applyStimulus(1, 16'd1000, lat);
        checkOutput("t3_1000_bcd",   32'(if165.bcd),   32'h01000);
        checkOutput("t3_1000_blank", 32'(if165.blank), 32'b10000);

        $display("[TB] 8-bit/2-digit overflow");
        applyStimulus(2, 16'd100, lat);
        checkOutput("t4_100_ovf",   32'(if82.ovf),   32'd1);
        checkOutput("t4_100_bcd",   32'(if82.bcd),   32'h99);
        checkOutput("t4_100_blank", 32'(if82.blank), 32'b00);
        applyStimulus(2, 16'd99, lat);
        checkOutput("t4_99_ovf", 32'(if82.ovf), 32'd0);
        checkOutput("t4_99_bcd", 32'(if82.bcd), 32'h99);
        applyStimulus(2, 16'd5, lat);
        checkOutput("t4_5_bcd",   32'(if82.bcd),   32'h05);
        checkOutput("t4_5_blank", 32'(if82.blank), 32'b10);

        $display("[TB] start ignored while busy");
        @(negedge clk);
        if83.bin   = 8'd12;
        if83.start = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if83.start = 1'b1;
            if83.bin   = 8'(i * 29 + 100);
            if (if83.done) dones++;
            checkOutput("t5_shift_rb", {30'd0, if83.ready, if83.busy}, 32'b01);
        end
        @(negedge clk);
        if83.start = 1'b0;
        if (if83.done) dones++;
        checkOutput("t5_done_rb", {30'd0, if83.ready, if83.busy}, 32'b01);
        checkOutput("t5_bcd",   32'(if83.bcd),   32'h012);
        checkOutput("t5_blank", 32'(if83.blank), 32'b100);
        repeat (6) begin
            @(negedge clk);
            if (if83.done) dones++;
        end
        checkOutput("t5_single_done", 32'(dones), 32'd1);
        checkOutput("t5_idle_ready", 32'(if83.ready), 32'd1);

        $display("[TB] reset mid-conversion");
        @(negedge clk);
        if83.bin   = 8'd200;
        if83.start = 1'b1;
        @(negedge clk);
        if83.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5r_ready", 32'(if83.ready), 32'd1);
        checkOutput("t5r_busy",  32'(if83.busy),  32'd0);
        checkOutput("t5r_done",  32'(if83.done),  32'd0);
        checkOutput("t5r_bcd",   32'(if83.bcd),   32'h000);
        checkOutput("t5r_blank", 32'(if83.blank), 32'b110);
        checkOutput("t5r_ovf",   32'(if83.ovf),   32'd0);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (if83.done) dones++;
        end
        checkOutput("t5r_no_done", 32'(dones), 32'd0);
        checkOutput("t5r_bcd_hold", 32'(if83.bcd), 32'h000);

        $display("[TB] back-to-back sweep 0..255");
        @(negedge clk);
        if83.bin   = 8'd0;
        if83.start = 1'b1;
        cyc  = 0;
        last = 0;
        for (int v = 0; v < 256; v++) begin
            n = 0;
            while (!if83.done && n < 30) begin
                @(negedge clk);
                n++;
                cyc++;
            end
            checkOutput("sweep_done", 32'(if83.done), 32'd1);
            e_bcd   = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            e_blank = {v < 100, v < 10, 1'b0};
            checkOutput("sweep_bcd",   32'(if83.bcd),   32'(e_bcd));
            checkOutput("sweep_blank", 32'(if83.blank), 32'(e_blank));
            checkOutput("sweep_ovf",   32'(if83.ovf),   32'd0);
            if (v > 0) checkOutput("sweep_spacing", 32'(cyc - last), 32'd10);
            last = cyc;
            if83.bin = 8'(v + 1);
            @(negedge clk);
            cyc++;
        end
        if83.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
